// File: rtl/mem_access_unit_if.sv
// CPU-side load/store handshake plus the word-wide data-memory port of mem_access_unit.
// The slave modport is the sequencer; the master modport is the CPU and memory together.
interface mem_access_unit_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    modport master (
        output req, we, size, uns, addr, wdata, mem_dout,
        input  busy, done, rdata, err, mem_addr, mem_din, mem_we
    );

    modport slave (
        input  req, we, size, uns, addr, wdata, mem_dout,
        output busy, done, rdata, err, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle load/store sequencer: byte/half/word accesses on a word-wide data memory,
// read-modify-write for narrow stores, lane extraction and sign/zero extension for loads.
module mem_access_unit #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic              clk,
    input  logic              rstn,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    lane_q, lane_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;

    logic          misaligned;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] ld_ext;
    logic [DW-1:0] st_merge;

    // Bytes above the 128-byte window alias and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:AW+2], bus.wdata[DW-1:16]};

    assign misaligned = (bus.size == 2'b11)
                     || (bus.size == 2'b01 && bus.addr[0])
                     || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);

    always_comb begin
        byte_sel = bus.mem_dout[7:0];
        unique case (lane_q)
            2'd0: byte_sel = bus.mem_dout[7:0];
            2'd1: byte_sel = bus.mem_dout[15:8];
            2'd2: byte_sel = bus.mem_dout[23:16];
            2'd3: byte_sel = bus.mem_dout[31:24];
            default: byte_sel = bus.mem_dout[7:0];
        endcase
        half_sel = lane_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];

        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: ld_ext = bus.mem_dout;
        endcase

        st_merge = bus.mem_dout;
        if (size_q == 2'b00) begin
            unique case (lane_q)
                2'd0: st_merge[7:0]   = wdata_q[7:0];
                2'd1: st_merge[15:8]  = wdata_q[7:0];
                2'd2: st_merge[23:16] = wdata_q[7:0];
                2'd3: st_merge[31:24] = wdata_q[7:0];
                default: st_merge = bus.mem_dout;
            endcase
        end else if (lane_q[1]) begin
            st_merge[31:16] = wdata_q;
        end else begin
            st_merge[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    we_d       = bus.we;
                    size_d     = bus.size;
                    uns_d      = bus.uns;
                    lane_d     = bus.addr[1:0];
                    wdata_d    = bus.wdata[15:0];
                    mem_addr_d = bus.addr[AW+1:2];
                    busy_d     = 1'b1;
                    if (misaligned) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (bus.we && bus.size == 2'b10) begin
                        state_d   = StWr;
                        mem_din_d = bus.wdata;
                        mem_we_d  = 1'b1;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (we_q) begin
                    state_d   = StWr;
                    mem_din_d = st_merge;
                    mem_we_d  = 1'b1;
                end else begin
                    state_d = StDone;
                    rdata_d = ld_ext;
                    done_d  = 1'b1;
                end
            end
            StWr: begin
                state_d = StDone;
                done_d  = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_we   = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected results, a
// negedge monitor pops and checks them whenever done pulses.
module tb_mem_access_unit;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(.AW(5), .DW(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] mem [32] = '{default: '0};
    assign bus.mem_dout = mem[bus.mem_addr];

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_wr   = 0;
    int   n_done = 0;
    logic [4:0] last_waddr = '0;

    always @(posedge clk) begin
        cyc++;
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_din;
            n_wr++;
            last_waddr = bus.mem_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rstn && bus.done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_err"}, {31'b0, bus.err}, {31'b0, e.er});
                chk({e.name, "_rdata"}, bus.rdata, e.rd);
                chk({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while ((bus.busy !== 1'b0 || sb.size() != 0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            n_chk++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d, expected idle", bus.busy,
                     sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input string name, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input logic er, input int lat, input bit push);
        wait_idle();
        @(negedge clk);
        bus.we    = w;
        bus.size  = sz;
        bus.uns   = u;
        bus.addr  = a;
        bus.wdata = wd;
        bus.req   = 1'b1;
        if (push) sb.push_back('{name, rd, er, lat, cyc + 1});
        @(posedge clk);
        #1 bus.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int d0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.size  = 2'b00;
        bus.uns   = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_err", {31'b0, bus.err}, 32'd0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_mem_din", bus.mem_din, 32'd0);
        chk("rst_mem_addr", {27'b0, bus.mem_addr}, 32'd0);
        rstn = 1'b1;

        issue("st_word", 1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0, 2, 1);
        wait_idle();
        chk("st_word_nwr", n_wr, 1);
        chk("st_word_waddr", {27'b0, last_waddr}, 32'd2);
        chk("st_word_mem", mem[2], 32'hDEADBEEF);

        issue("ld_word", 0, 2'b10, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, 2, 1);
        issue("st_byte", 1, 2'b00, 0, 32'h09, 32'h12, 32'hDEADBEEF, 0, 3, 1);
        wait_idle();
        chk("st_byte_mem", mem[2], 32'hDEAD12EF);
        chk("st_byte_nwr", n_wr, 2);

        issue("ld_b3_s", 0, 2'b00, 0, 32'h0B, 32'h0, 32'hFFFFFFDE, 0, 2, 1);
        issue("ld_b3_u", 0, 2'b00, 1, 32'h0B, 32'h0, 32'h000000DE, 0, 2, 1);
        issue("ld_h1_s", 0, 2'b01, 0, 32'h0A, 32'h0, 32'hFFFFDEAD, 0, 2, 1);
        issue("ld_h0_u", 0, 2'b01, 1, 32'h08, 32'h0, 32'h000012EF, 0, 2, 1);
        issue("ld_b1_s", 0, 2'b00, 0, 32'h09, 32'h0, 32'h00000012, 0, 2, 1);
        issue("st_half", 1, 2'b01, 0, 32'h0A, 32'hCAFE1234, 32'h00000012, 0, 3, 1);
        wait_idle();
        chk("st_half_mem", mem[2], 32'h123412EF);
        issue("ld_alias", 0, 2'b10, 0, 32'hFFFFFF88, 32'h0, 32'h123412EF, 0, 2, 1);

        w0 = n_wr;
        issue("mis_st_word", 1, 2'b10, 0, 32'h06, 32'h55555555, 32'h123412EF, 1, 1, 1);
        issue("mis_ld_half", 0, 2'b01, 0, 32'h03, 32'h0, 32'h123412EF, 1, 1, 1);
        issue("rsv_size", 0, 2'b11, 0, 32'h00, 32'h0, 32'h123412EF, 1, 1, 1);
        wait_idle();
        chk("mis_nwr", n_wr, w0);

        // Second request arrives while the byte RMW is in flight and must be dropped.
        w0 = n_wr;
        d0 = n_done;
        issue("busy_st", 1, 2'b00, 0, 32'h00, 32'hA5, 32'h123412EF, 0, 3, 1);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.size  = 2'b10;
        bus.addr  = 32'h10;
        bus.wdata = 32'hFFFFFFFF;
        bus.req   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        wait_idle();
        chk("busy_nwr", n_wr - w0, 1);
        chk("busy_ndone", n_done - d0, 1);
        chk("busy_mem4", mem[4], 32'h0);
        chk("busy_mem0", mem[0], 32'h000000A5);
        issue("ld_mem4", 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 2, 1);

        issue("rst_st", 1, 2'b00, 0, 32'h0F, 32'h77, 32'h0, 0, 3, 0);
        @(negedge clk);
        @(negedge clk);
        chk("wr_mem_we", {31'b0, bus.mem_we}, 32'd1);
        chk("wr_mem_din", bus.mem_din, 32'h77000000);
        w0 = n_wr;
        rstn = 1'b0;
        #1;
        chk("midrst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_nwr", n_wr, w0);
        chk("midrst_mem3", mem[3], 32'h0);
        issue("ld_mem3", 0, 2'b10, 0, 32'h0C, 32'h0, 32'h0, 0, 2, 1);
        issue("ld_mem0", 0, 2'b10, 0, 32'h00, 32'h0, 32'h000000A5, 0, 2, 1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multicycle load/store sequencer between the CPU datapath's MEM state and the word-wide 32-entry data memory (`dm_4k`).
- Converts byte/halfword/word requests at byte addresses into word accesses:
  - Stores narrower than a word use read-modify-write.
  - Loads use lane extraction plus sign/zero extension.
- Drives the data memory's address, write-data and write-enable inputs, and consumes its combinational read data.

Parameters:
- AW, 5, data-memory word-address width (32 words).
- DW, 32, data width; fixed at 32, not generic.

Ports:
- clk  input  1  clock; all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- uns  input  1  load zero-extends when 1, sign-extends when 0.
- addr  input  32  byte address; addr[6:2] = word index, addr[1:0] = lane.
- wdata  input  32  store data; the low byte/half is used for sub-word stores.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at completion.
- rdata  output  32  load result; valid while done=1, held until the next load's done.
- err  output  1  valid with done; misaligned or reserved size.
- mem_addr  output  5  to data memory addr.
- mem_din  output  32  to data memory din.
- mem_we  output  1  to data memory DMWr.
- mem_dout  input  32  from data memory dout; combinational read of mem_addr.

Behaviour:
- Reset (async, rstn=0): state=IDLE; busy, done, err, mem_we = 0; rdata, mem_din = 0; mem_addr = 0. All outputs are registered.
- States: IDLE, RD, WR, DONE.
- IDLE with req=1: latch we, size, uns, addr[6:0], wdata; set mem_addr = addr[6:2].
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=11): go to DONE with err=1. No memory write occurs.
  - Load, or sub-word store: go to RD.
  - Word store: go to WR; on the same edge load mem_din=wdata and mem_we=1.
- RD: capture mem_dout into the internal word register.
  - Load: extract the lane and extend into rdata, then go to DONE.
  - Byte lane: offset 0 = bits 7:0, 1 = 15:8, 2 = 23:16, 3 = 31:24 (little-endian).
  - Half lane: addr[1]=0 → 15:0, 1 → 31:16.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane of mem_dout, leaving other lanes unchanged. Load mem_din=merged and mem_we=1 on the same edge, then go to WR.
- WR: mem_we=1 for exactly this one cycle; on exit mem_we=0 and go to DONE.
- mem_din stability:
  - mem_din changes only on the edge entering WR.
  - mem_din holds its value afterwards, so a din change never coincides with mem_we=1 outside WR.
- DONE: done=1 for one cycle (err as decided), then go to IDLE.
  - busy deasserts on the edge entering IDLE.
  - done/err return to 0 in IDLE.
- Latency from the accepting edge to the edge where done is seen high:
  - load: 2 cycles (IDLE→RD→DONE)
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- req while busy is ignored, not queued. req held high in IDLE after DONE starts a new access.
- addr[31:7] is ignored; addresses alias modulo 128 bytes.
- rdata is unchanged by stores and errors.
- rstn asserted mid-access (including during WR) returns to reset values immediately and forces mem_we=0. A partially sequenced read-modify-write is abandoned without writing.

Test Plan:
- Word store then load: store addr=0x08, wdata=0xDEADBEEF (done after 2 cycles, mem_we high 1 cycle at mem_addr=2). Then load word from 0x08 → rdata=0xDEADBEEF, err=0.
- Byte store RMW: with mem[2]=0xDEADBEEF, store byte addr=0x09, wdata=0x12 → mem[2]=0xDEAD12EF, done 3 cycles after acceptance.
- Sign/zero extension: load byte from 0x0B with uns=0 → 0xFFFFFFDE; same with uns=1 → 0x000000DE; load half from 0x0A with uns=0 → 0xFFFFDEAD.
- Misaligned: word store to 0x06 and half load at 0x03 → done+err after 1 cycle, mem_we never asserted, rdata unchanged.
- Busy ignore: pulse req for a second store during an active RMW → only the first access occurs, exactly one done pulse.
- Reset mid-WR: drop rstn during the WR cycle of a byte store → mem_we falls asynchronously, busy=0, no further write after release, next load returns consistent data.
